cc_apb_master: RTL and testbench
================================

// Module: cc_apb_master
// PURPOSE
// - APB requester (initiator) for the cache-controller config space; the initiating end of the APB3 slave ports.
// - Turns one-at-a-time requests on a valid/ready command interface into APB SETUP/ACCESS transfers.
// - Returns read data / error on a valid/ready response interface.
// - Sits between the test/CPU-side control logic and the APB config slaves.
// PARAMETERS
// - ADDR_W          12   APB address width (paddr_o / req_addr_i)
// - DATA_W          32   APB data width
// - TIMEOUT_CYCLES  16   max ACCESS cycles waiting for pready_i; 0 disables the timeout
// PORTS
// - clk           in   1       clock, all logic on posedge
// - rst_n         in   1       asynchronous active-low reset
// - req_valid_i   in   1       command valid
// - req_ready_o   out  1       command accepted when valid & ready
// - req_write_i   in   1       1 = write, 0 = read
// - req_addr_i    in   ADDR_W  target address
// - req_wdata_i   in   DATA_W  write data
// - rsp_valid_o   out  1       response valid, held until rsp_ready_i
// - rsp_ready_i   in   1       response consumer ready
// - rsp_rdata_o   out  DATA_W  read data; 0 for writes and for errors
// - rsp_err_o     out  1       pslverr_i seen, or timeout
// - psel_o        out  1       APB select
// - penable_o     out  1       APB enable
// - paddr_o       out  ADDR_W  APB address
// - pwrite_o      out  1       APB direction
// - pwdata_o      out  DATA_W  APB write data
// - pready_i      in   1       APB ready
// - prdata_i      in   DATA_W  APB read data
// - pslverr_i     in   1       APB error
// BEHAVIOUR
// - Reset (async, rst_n=0): state IDLE; every output 0 immediately, incl. req_ready_o; timeout counter 0.
// - All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
// - FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE.
//   - IDLE: req_ready_o=1. On req_valid_i, capture addr/wdata/write into paddr_o/pwdata_o/pwrite_o and go to SETUP.
//   - SETUP: psel_o=1, penable_o=0, exactly 1 cycle, then ACCESS.
//   - ACCESS: psel_o=1, penable_o=1; paddr/pwrite/pwdata held stable.
//     - pready_i=1: capture the response and go to RESP.
//       - rsp_rdata_o = pwrite_o ? 0 : prdata_i.
//       - rsp_err_o = pslverr_i; if pslverr_i, rsp_rdata_o = 0.
//     - pready_i=0: increment the timeout counter.
//     - Timeout: counter == TIMEOUT_CYCLES-1 with pready_i still 0 -> go to RESP with rsp_err_o=1, rsp_rdata_o=0.
//     - pready_i=1 in the timeout cycle wins over the timeout.
//   - RESP: psel_o=penable_o=0; rsp_valid_o=1 until rsp_ready_i=1 (inclusive), then IDLE.
//     - Outputs stay stable while stalled; req_ready_o=0.
// - Latency: request accepted at cycle T -> SETUP at T+1 -> ACCESS at T+2; with pready_i=1 there, rsp_valid_o=1 at T+3.
//   - Back-to-back throughput: one transfer per 4 cycles minimum.
// - psel_o deasserts between transfers (no SETUP-to-SETUP chaining).
// - paddr_o/pwdata_o/pwrite_o hold their last value in IDLE/RESP; only psel_o gates them.
// - req_*_i are ignored outside IDLE; rsp_ready_i is ignored outside RESP.
// - Timeout counter clears on entering SETUP; it saturates and never wraps.
// - Reset mid-transfer: the bus drops immediately and the response is lost; the requester must reissue.
// STRUCTURE
// - Package cc_apb_pkg holds:
//   - typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_t;
//   - localparams APB_ADDR_W=12, APB_DATA_W=32.
// - Single module, no sub-modules.
// - Timeout counter width: $clog2(TIMEOUT_CYCLES+1), minimum 1.
// TESTING (bench APB slave model with programmable wait states and error)
// - Read 0x000, slave 0 waits, prdata=32'h0002_2025:
//   - psel at T+1, penable at T+2, rsp_valid at T+3, rdata=32'h0002_2025, err=0.
// - Write 0x010 data 32'hDEAD_BEEF, slave inserts 3 waits:
//   - paddr/pwdata/pwrite stable for all 4 ACCESS cycles; rsp rdata=0, err=0.
// - Read with pslverr_i=1 and prdata=32'h1234_5678: rsp err=1, rdata=0.
// - Slave never ready, TIMEOUT_CYCLES=16:
//   - exactly 16 ACCESS cycles, then psel_o=0, rsp err=1, rdata=0.
//   - pready_i=1 in cycle 16 instead -> normal completion, err=0.
// - rsp_ready_i held low 5 cycles:
//   - rsp_valid_o/rdata stable, req_ready_o=0, no new APB transfer.
//   - Then back-to-back requests each take 4 cycles.
// - Assert rst_n=0 during ACCESS:
//   - psel_o/penable_o/rsp_valid_o=0 in the same cycle.
//   - After release, req_ready_o=1 and a new read completes correctly.

Source files
------------

// File: rtl/cc_apb_pkg.sv
// Shared types and widths for the cache-controller APB requester.
package cc_apb_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apb_mst_state_t;

    localparam int APB_ADDR_W = 12;
    localparam int APB_DATA_W = 32;

    // Timeout counter width; a disabled timeout (0) still needs one bit.
    function automatic int tmo_cnt_w(input int cycles);
        return (cycles > 0) ? $clog2(cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/cc_apb_master_if.sv
// Command/response handshake plus APB3 bus of the config-space requester.
interface cc_apb_master_if
    import cc_apb_pkg::*;
#(
    parameter int ADDR_W = APB_ADDR_W,
    parameter int DATA_W = APB_DATA_W
);
    logic              req_valid_i;
    logic              req_ready_o;
    logic              req_write_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic [DATA_W-1:0] req_wdata_i;

    logic              rsp_valid_o;
    logic              rsp_ready_i;
    logic [DATA_W-1:0] rsp_rdata_o;
    logic              rsp_err_o;

    logic              psel_o;
    logic              penable_o;
    logic [ADDR_W-1:0] paddr_o;
    logic              pwrite_o;
    logic [DATA_W-1:0] pwdata_o;
    logic              pready_i;
    logic [DATA_W-1:0] prdata_i;
    logic              pslverr_i;

    modport master (
        input  req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
        input  pready_i, prdata_i, pslverr_i,
        output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        output psel_o, penable_o, paddr_o, pwrite_o, pwdata_o
    );

    modport slave (
        output req_valid_i, req_write_i, req_addr_i, req_wdata_i, rsp_ready_i,
        output pready_i, prdata_i, pslverr_i,
        input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o,
        input  psel_o, penable_o, paddr_o, pwrite_o, pwdata_o
    );

endinterface

// File: rtl/cc_apb_master.sv
// APB3 requester: one command at a time becomes a SETUP/ACCESS transfer plus a response.
// Latency: accept at T, SETUP T+1, ACCESS T+2, response valid T+3 with zero wait states.
// Backpressure: req_ready only in IDLE; response held until rsp_ready; slave waits bounded by timeout.
module cc_apb_master
    import cc_apb_pkg::*;
#(
    parameter int ADDR_W         = APB_ADDR_W,
    parameter int DATA_W         = APB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic            clk,
    input  logic            rst_n,
    cc_apb_master_if.master bus
);

    localparam int               CNT_W    = tmo_cnt_w(TIMEOUT_CYCLES);
    localparam bit               TMO_EN   = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] TMO_LAST = TMO_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    apb_mst_state_t    state_q, state_d;
    logic [CNT_W-1:0]  tcnt_q;
    logic              req_rdy_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              write_q;
    logic [DATA_W-1:0] rdata_q;
    logic              err_q;
    logic              accept;
    logic              timeout;
    logic              access_done;

    // req_rdy_q is its own flop so ready stays low while reset is asserted.
    assign accept      = req_rdy_q && bus.req_valid_i;
    assign timeout     = TMO_EN && !bus.pready_i && (tcnt_q == TMO_LAST);
    assign access_done = (state_q == ACCESS) && (bus.pready_i || timeout);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (accept)          state_d = SETUP;
            SETUP:                        state_d = ACCESS;
            ACCESS:  if (access_done)     state_d = RESP;
            RESP:    if (bus.rsp_ready_i) state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_rdy_q <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            write_q   <= 1'b0;
            tcnt_q    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            req_rdy_q <= (state_d == IDLE);

            if (accept) begin
                addr_q  <= bus.req_addr_i;
                wdata_q <= bus.req_wdata_i;
                write_q <= bus.req_write_i;
            end

            // Saturating wait counter, restarted for every new transfer.
            if (accept) begin
                tcnt_q <= '0;
            end else if (state_q == ACCESS && !bus.pready_i && tcnt_q != '1) begin
                tcnt_q <= tcnt_q + 1'b1;
            end

            if (access_done) begin
                rdata_q <= (bus.pready_i && !write_q && !bus.pslverr_i) ? bus.prdata_i : '0;
                err_q   <= bus.pready_i ? bus.pslverr_i : 1'b1;
            end
        end
    end

    assign bus.req_ready_o = req_rdy_q;
    assign bus.psel_o      = (state_q == SETUP) || (state_q == ACCESS);
    assign bus.penable_o   = (state_q == ACCESS);
    assign bus.paddr_o     = addr_q;
    assign bus.pwdata_o    = wdata_q;
    assign bus.pwrite_o    = write_q;
    assign bus.rsp_valid_o = (state_q == RESP);
    assign bus.rsp_rdata_o = rdata_q;
    assign bus.rsp_err_o   = err_q;

endmodule

// File: tb/tb_cc_apb_master.sv
// Bench for cc_apb_master: wait-state/error APB slave model plus per-transfer reference expectations.
module tb_cc_apb_master;
    import cc_apb_pkg::*;

    localparam int AW  = APB_ADDR_W;
    localparam int DW  = APB_DATA_W;
    localparam int TMO = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_bad = 0;
    int   last_acc = -100;

    int            sl_waits = 0;
    logic          sl_err = 1'b0;
    logic [DW-1:0] sl_rdata = '0;
    int            acc_n = 0;

    cc_apb_master_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

    cc_apb_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: ACCESS cycles seen by the slave for a given wait count.
    function automatic int exp_nacc(input int waits);
        return (waits >= TMO) ? TMO : waits + 1;
    endfunction

    // APB slave: ready after sl_waits ACCESS cycles; junk on data/err while not ready.
    initial begin
        bus.pready_i  = 1'b0;
        bus.prdata_i  = '0;
        bus.pslverr_i = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.psel_o && bus.penable_o) begin
                bus.pready_i  = (acc_n == sl_waits);
                bus.prdata_i  = bus.pready_i ? sl_rdata : DW'($urandom);
                bus.pslverr_i = bus.pready_i ? sl_err : 1'($urandom);
                acc_n++;
            end else begin
                bus.pready_i  = 1'b0;
                bus.prdata_i  = DW'($urandom);
                bus.pslverr_i = 1'($urandom);
                acc_n = 0;
            end
        end
    end

    task automatic drive_junk();
        bus.req_valid_i = 1'($urandom);
        bus.req_write_i = 1'($urandom);
        bus.req_addr_i  = AW'($urandom);
        bus.req_wdata_i = DW'($urandom);
    endtask

    // Called just after a negedge; returns just after a negedge in the following IDLE cycle.
    task automatic do_xfer(input logic wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                           input int waits, input logic serr, input logic [DW-1:0] rd,
                           input int stall, input bit b2b);
        int            t_acc, psel_c, pen_c, rsp_c, n_acc;
        bit            stable, st_ok, acc_ok;
        logic          e_err;
        logic [DW-1:0] e_rdata;
        e_err   = (waits >= TMO) || serr;
        e_rdata = (wr || e_err) ? '0 : rd;
        sl_waits = waits;
        sl_err   = serr;
        sl_rdata = rd;

        bus.rsp_ready_i = 1'b0;
        bus.req_valid_i = 1'b1;
        bus.req_write_i = wr;
        bus.req_addr_i  = a;
        bus.req_wdata_i = wd;
        acc_ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready_o) begin
                acc_ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("accept", acc_ok, 1);
        t_acc = cyc;
        if (b2b) chk("b2b_interval", t_acc - last_acc, 4);
        last_acc = t_acc;
        @(posedge clk);

        psel_c = -1; pen_c = -1; rsp_c = -1; n_acc = 0; stable = 1'b1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.rsp_valid_o) begin
                rsp_c = cyc;
                break;
            end
            drive_junk();
            bus.rsp_ready_i = 1'($urandom);
            if (bus.psel_o && psel_c < 0) psel_c = cyc;
            if (bus.penable_o && pen_c < 0) pen_c = cyc;
            if (bus.psel_o && bus.penable_o) begin
                n_acc++;
                if (bus.paddr_o !== a || bus.pwrite_o !== wr || bus.pwdata_o !== wd) stable = 1'b0;
            end
        end
        bus.rsp_ready_i = 1'b0;

        chk("rsp_seen", rsp_c >= 0, 1);
        chk("psel_lat", psel_c - t_acc, 1);
        chk("pen_lat", pen_c - t_acc, 2);
        chk("n_access", n_acc, exp_nacc(waits));
        chk("rsp_lat", rsp_c - t_acc, 2 + exp_nacc(waits));
        chk("bus_stable", stable, 1);
        chk("rdata", bus.rsp_rdata_o, e_rdata);
        chk("err", bus.rsp_err_o, e_err);

        st_ok = 1'b1;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            drive_junk();
            if (!bus.rsp_valid_o || bus.rsp_rdata_o !== e_rdata || bus.rsp_err_o !== e_err ||
                bus.req_ready_o || bus.psel_o) st_ok = 1'b0;
        end
        if (stall > 0) chk("stall_hold", st_ok, 1);

        bus.req_valid_i = 1'b0;
        bus.rsp_ready_i = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("rsp_drop", bus.rsp_valid_o, 0);
        chk("idle_ready", bus.req_ready_o, 1);
        bus.rsp_ready_i = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctl"}, {bus.psel_o, bus.penable_o, bus.req_ready_o, bus.rsp_valid_o,
                            bus.rsp_err_o, bus.pwrite_o}, 0);
        chk({tag, "_data"}, {bus.paddr_o, bus.rsp_rdata_o}, 0);
        chk({tag, "_wdata"}, bus.pwdata_o, 0);
    endtask

    initial begin
        int   w;
        bit   acc_ok;
        rst_n           = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.req_wdata_i = '0;
        bus.rsp_ready_i = 1'b0;
        #1;
        check_reset_outputs("rst0");
        repeat (3) @(negedge clk);
        check_reset_outputs("rst_hold");
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_rel_ready", bus.req_ready_o, 1);

        do_xfer(1'b0, 12'h000, 32'h0, 0, 1'b0, 32'h0002_2025, 0, 1'b0);
        do_xfer(1'b1, 12'h010, 32'hDEAD_BEEF, 3, 1'b0, 32'hCAFE_F00D, 0, 1'b0);
        do_xfer(1'b0, 12'h024, 32'h0, 1, 1'b1, 32'h1234_5678, 0, 1'b0);
        do_xfer(1'b0, 12'h030, 32'h0, 1000, 1'b0, 32'hAAAA_5555, 0, 1'b0);
        do_xfer(1'b0, 12'h034, 32'h0, TMO - 1, 1'b0, 32'h0BAD_CAFE, 0, 1'b0);
        do_xfer(1'b1, 12'h038, 32'h0102_0304, TMO - 1, 1'b1, 32'h0, 0, 1'b0);
        do_xfer(1'b0, 12'h040, 32'h0, 0, 1'b0, 32'h5A5A_A5A5, 5, 1'b0);
        do_xfer(1'b0, 12'h044, 32'h0, 0, 1'b0, 32'h1111_0001, 0, 1'b0);
        do_xfer(1'b1, 12'h048, 32'h2222_0002, 0, 1'b0, 32'h0, 0, 1'b1);
        do_xfer(1'b0, 12'h04C, 32'h0, 0, 1'b0, 32'h3333_0003, 0, 1'b1);
        do_xfer(1'b0, 12'hFFC, 32'h0, 0, 1'b0, 32'hFFFF_FFFF, 0, 1'b1);

        // Reset while the slave is stalling in ACCESS.
        sl_waits = 1000;
        bus.req_valid_i = 1'b1;
        bus.req_write_i = 1'b0;
        bus.req_addr_i  = 12'h0F0;
        acc_ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (bus.req_ready_o) begin
                acc_ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        chk("mid_accept", acc_ok, 1);
        @(posedge clk);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        repeat (3) @(negedge clk);
        chk("mid_in_access", {bus.psel_o, bus.penable_o}, 2'b11);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_bus", {bus.psel_o, bus.penable_o, bus.rsp_valid_o, bus.req_ready_o}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_ready", bus.req_ready_o, 1);
        do_xfer(1'b0, 12'h0F4, 32'h0, 2, 1'b0, 32'h0002_2025, 1, 1'b0);

        for (int n = 0; n < 25; n++) begin
            case ($urandom_range(0, 5))
                0, 1, 2, 3: w = $urandom_range(0, 3);
                4:          w = $urandom_range(TMO - 3, TMO);
                default:    w = $urandom_range(TMO + 1, TMO + 14);
            endcase
            do_xfer(1'($urandom), AW'($urandom), DW'($urandom), w,
                    ($urandom_range(0, 4) == 0), DW'($urandom), $urandom_range(0, 3), 1'b0);
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog total=%0d bad=%0d", n_chk, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule
